// File: rtl/cam_window_writer.sv
// Camera capture stage: tracks pixel x/y, crops a fixed window and writes it
// row-major into a frame buffer, as RGB565 passthrough or grayscale.
module cam_window_writer #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int WIN_X0  = 0,
  parameter int WIN_Y0  = 0,
  parameter int WIN_W   = 256,
  parameter int WIN_H   = 256,
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  input  logic              frame_start,
  input  logic              capture_en,
  input  logic              gray_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [9:0]        cur_x,
  output logic [8:0]        cur_y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  localparam logic [9:0] X_LAST = 10'(FRAME_W - 1);
  localparam logic [8:0] Y_LAST = 9'(FRAME_H - 1);
  localparam logic [9:0] X_LO   = 10'(WIN_X0);
  localparam logic [8:0] Y_LO   = 9'(WIN_Y0);
  localparam logic [9:0] W_X    = 10'(WIN_W);
  localparam logic [8:0] W_Y    = 9'(WIN_H);

  // Y = (77*R8 + 150*G8 + 29*B8) >> 8, replicated back into RGB565 fields.
  function automatic logic [15:0] gray565(input logic [15:0] p);
    logic [7:0] r8;
    logic [7:0] g8;
    logic [7:0] b8;
    logic [5:0] y6;
    r8 = {p[15:11], p[15:13]};
    g8 = {p[10:5], p[10:9]};
    b8 = {p[4:0], p[4:2]};
    y6 = 6'((16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8}) >> 10);
    return {y6[5:1], y6, y6[5:1]};
  endfunction

  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d, x_e, dx_s;
  logic [8:0]          y_q, y_d, y_e, dy_s;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_e;
  logic                gray_q, gray_d, gray_e;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_s, take_s, in_win_s;

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    gray_d    = gray_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    start_s   = 1'b0;
    take_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_en) state_d = ARMED;
        else            state_d = IDLE;
      end
      ARMED: begin
        if (frame_start) begin
          state_d = CAPTURE;
          start_s = 1'b1;
          take_s  = pix_valid;
        end else begin
          state_d = ARMED;
        end
      end
      CAPTURE: begin
        // A vsync inside a frame aborts it; the new frame starts right here.
        if (frame_start) begin
          start_s = 1'b1;
          err_d   = 1'b1;
        end else begin
          err_d   = 1'b0;
        end
        take_s = pix_valid;
      end
      FROZEN: begin
        if (capture_en) state_d = ARMED;
        else            state_d = FROZEN;
      end
      default: state_d = IDLE;
    endcase

    // A pixel coinciding with frame_start belongs to (0,0) of the new frame.
    x_e    = start_s ? 10'd0 : x_q;
    y_e    = start_s ? 9'd0 : y_q;
    addr_e = start_s ? '0 : addr_q;
    gray_e = start_s ? gray_mode : gray_q;
    // Offsets below the window wrap to large values, so one compare per axis.
    dx_s     = x_e - X_LO;
    dy_s     = y_e - Y_LO;
    in_win_s = (dx_s < W_X) && (dy_s < W_Y);

    if (start_s) begin
      x_d    = 10'd0;
      y_d    = 9'd0;
      addr_d = '0;
      gray_d = gray_mode;
    end else begin
      gray_d = gray_q;
    end

    if (take_s) begin
      if (in_win_s) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_e;
        wr_data_d = gray_e ? gray565(pix_data) : pix_data;
        addr_d    = addr_e + ADDR_W'(1);
      end else begin
        wr_en_d   = 1'b0;
      end
      if (x_e == X_LAST) begin
        x_d = 10'd0;
        if (y_e == Y_LAST) begin
          y_d     = 9'd0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = capture_en ? ARMED : FROZEN;
        end else begin
          y_d = y_e + 9'd1;
        end
      end else begin
        x_d = x_e + 10'd1;
      end
    end else begin
      wr_en_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= 10'd0;
      y_q       <= 9'd0;
      addr_q    <= '0;
      gray_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      gray_q    <= gray_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = (state_q == CAPTURE);
  assign frame_cnt  = cnt_q;
  assign cur_x      = x_q;
  assign cur_y      = y_q;

endmodule
